// File: rtl/johnson_phase_monitor_pkg.sv
// Shared definitions for consumers of the 8-phase Johnson counter decode lines.
package johnson_phase_monitor_pkg;

    localparam int NPHASE = 8;
    localparam int PIDX_W = 3;

    // Monitor FSM states
    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_LOCKING = 2'd1,
        ST_LOCKED  = 2'd2,
        ST_FAULT   = 2'd3
    } mon_state_t;

    // Mask of phase lines whose index has bit b set; used to build the encoder
    // as one OR-reduction per index bit.
    function automatic logic [NPHASE-1:0] idx_mask(input int b);
        logic [NPHASE-1:0] m;
        m = '0;
        for (int i = 0; i < NPHASE; i++) begin
            m[i] = (((i >> b) & 1) != 0);
        end
        return m;
    endfunction

endpackage

// File: rtl/johnson_phase_monitor_onehot8_encode.sv
// Combinational 8->3 one-hot encoder with exactly-one-hot check.
// idx is only meaningful when valid is high.
module onehot8_encode
    import johnson_phase_monitor_pkg::*;
(
    input  logic [NPHASE-1:0] phase,
    output logic [PIDX_W-1:0] idx,
    output logic              valid
);

    // Each index bit is the OR of the lines whose position has that bit set
    generate
        for (genvar gi = 0; gi < PIDX_W; gi++) begin : g_idx
            assign idx[gi] = |(phase & idx_mask(gi));
        end
    endgenerate

    // Exactly one bit set: non-zero and clearing the lowest set bit leaves zero
    assign valid = (phase != '0) && ((phase & (phase - 1'b1)) == '0);

endmodule

// File: rtl/johnson_phase_monitor.sv
// Phase monitor for the 8-phase Johnson counter: encodes the decode lines,
// tracks legal rotation, locks, counts revolutions and flags sequence faults.
module johnson_phase_monitor
    import johnson_phase_monitor_pkg::*;
#(
    parameter int LOCK_LEN = 4,
    parameter int RW       = 8,
    parameter int EW       = 4
) (
    input  logic              clk,
    input  logic              clear,
    input  logic [NPHASE-1:0] phase,
    input  logic              err_clr,
    output logic [PIDX_W-1:0] phase_idx,
    output logic              phase_valid,
    output logic              locked,
    output logic              rev_pulse,
    output logic [RW-1:0]     rev_count,
    output logic              err,
    output logic [EW-1:0]     err_count
);

    localparam logic [3:0]    LOCK_TARGET = 4'(LOCK_LEN);
    localparam logic [RW-1:0] REV_ONE     = {{(RW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0] ERR_ONE     = {{(EW-1){1'b0}}, 1'b1};
    localparam logic [EW-1:0] ERR_MAX     = {EW{1'b1}};

    logic [PIDX_W-1:0] samp_idx;
    logic              samp_valid;

    mon_state_t        state_reg;
    logic [PIDX_W-1:0] prev_idx_reg;
    logic [3:0]        adv_cnt_reg;
    logic [PIDX_W-1:0] phase_idx_reg;
    logic              phase_valid_reg;
    logic              locked_reg;
    logic              rev_pulse_reg;
    logic [RW-1:0]     rev_count_reg;
    logic              err_reg;
    logic [EW-1:0]     err_count_reg;

    logic [PIDX_W-1:0] idx_diff;
    logic              is_adv;
    logic              is_hold;
    logic [3:0]        adv_cnt_inc;

    onehot8_encode u_encode (
        .phase (phase),
        .idx   (samp_idx),
        .valid (samp_valid)
    );

    // Classify the incoming sample relative to the last tracked index;
    // modulo-8 subtraction makes 7->0 an ordinary advance.
    assign idx_diff    = samp_idx - prev_idx_reg;
    assign is_adv      = samp_valid && (idx_diff == 3'd1);
    assign is_hold     = samp_valid && (idx_diff == 3'd0);
    assign adv_cnt_inc = adv_cnt_reg + 4'd1;

    // Register the encoded sample; an invalid sample keeps the last good index
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            phase_valid_reg <= 1'b0;
            phase_idx_reg   <= '0;
        end else begin
            phase_valid_reg <= samp_valid;
            if (samp_valid) begin
                phase_idx_reg <= samp_idx;
            end
        end
    end

    // Lock FSM with revolution and fault bookkeeping
    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_reg     <= ST_HUNT;
            prev_idx_reg  <= '0;
            adv_cnt_reg   <= '0;
            locked_reg    <= 1'b0;
            rev_pulse_reg <= 1'b0;
            rev_count_reg <= '0;
            err_reg       <= 1'b0;
            err_count_reg <= '0;
        end else begin
            rev_pulse_reg <= 1'b0;
            // A fault detected below on the same edge overrides this clear
            if (err_clr) begin
                err_reg <= 1'b0;
            end

            case (state_reg)
                ST_HUNT: begin
                    if (samp_valid) begin
                        state_reg    <= ST_LOCKING;
                        prev_idx_reg <= samp_idx;
                        adv_cnt_reg  <= '0;
                    end
                end

                ST_LOCKING: begin
                    if (!samp_valid) begin
                        state_reg <= ST_HUNT;
                    end else if (is_adv) begin
                        prev_idx_reg <= samp_idx;
                        adv_cnt_reg  <= adv_cnt_inc;
                        if (adv_cnt_inc == LOCK_TARGET) begin
                            state_reg  <= ST_LOCKED;
                            locked_reg <= 1'b1;
                        end
                    end else if (!is_hold) begin
                        // Skip: restart the advance run from the new position
                        prev_idx_reg <= samp_idx;
                        adv_cnt_reg  <= '0;
                    end
                end

                ST_LOCKED: begin
                    if (is_adv || is_hold) begin
                        prev_idx_reg <= samp_idx;
                        if (is_adv && (samp_idx == '0)) begin
                            rev_pulse_reg <= 1'b1;
                            rev_count_reg <= rev_count_reg + REV_ONE;
                        end
                    end else begin
                        state_reg  <= ST_FAULT;
                        locked_reg <= 1'b0;
                        err_reg    <= 1'b1;
                        if (err_count_reg != ERR_MAX) begin
                            err_count_reg <= err_count_reg + ERR_ONE;
                        end
                        if (samp_valid) begin
                            prev_idx_reg <= samp_idx;
                        end
                    end
                end

                ST_FAULT: begin
                    state_reg <= ST_HUNT;
                end

                default: begin
                    state_reg <= ST_HUNT;
                end
            endcase
        end
    end

    assign phase_idx   = phase_idx_reg;
    assign phase_valid = phase_valid_reg;
    assign locked      = locked_reg;
    assign rev_pulse   = rev_pulse_reg;
    assign rev_count   = rev_count_reg;
    assign err         = err_reg;
    assign err_count   = err_count_reg;

endmodule

// File: tb/tb_johnson_phase_monitor.sv
// Randomized self-checking bench for johnson_phase_monitor.
module tb_johnson_phase_monitor;

    localparam int LOCK_LEN = 4;
    localparam int RW       = 8;
    localparam int EW       = 4;
    localparam int NCYC     = 6000;

    logic          clk;
    logic          clear;
    logic [7:0]    phase;
    logic          err_clr;
    logic [2:0]    phase_idx;
    logic          phase_valid;
    logic          locked;
    logic          rev_pulse;
    logic [RW-1:0] rev_count;
    logic          err;
    logic [EW-1:0] err_count;

    int n_checks = 0;
    int n_errors = 0;

    johnson_phase_monitor #(
        .LOCK_LEN (LOCK_LEN),
        .RW       (RW),
        .EW       (EW)
    ) dut (
        .clk         (clk),
        .clear       (clear),
        .phase       (phase),
        .err_clr     (err_clr),
        .phase_idx   (phase_idx),
        .phase_valid (phase_valid),
        .locked      (locked),
        .rev_pulse   (rev_pulse),
        .rev_count   (rev_count),
        .err         (err),
        .err_count   (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain integers, the expected visible outputs plus the
    // tracking facts the rules talk about (seeded?, run of advances, last index).
    bit m_seeded, m_locked, m_faulted;
    int m_prev, m_run;
    int e_idx, e_valid, e_pulse, e_revs, e_err, e_errs;
    int max_errs_seen = 0;
    int revs_seen     = 0;

    task automatic check_value(input string tag, input int observed, input int expected);
        n_checks++;
        if (observed != expected) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
        end
    endtask

    function automatic void model_reset();
        m_seeded = 0; m_locked = 0; m_faulted = 0;
        m_prev = 0; m_run = 0;
        e_idx = 0; e_valid = 0; e_pulse = 0; e_revs = 0; e_err = 0; e_errs = 0;
    endfunction

    // Apply one clock edge worth of the rules to the model
    function automatic void model_step(input logic [7:0] p, input bit clr_req);
        bit valid;
        int idx, step;
        bit fault;
        valid = ($countones(p) == 1);
        idx = 0;
        for (int i = 0; i < 8; i++) if (p[i]) idx = i;
        step  = (idx - m_prev + 8) % 8;
        fault = 0;
        e_pulse = 0;
        e_valid = valid;
        if (valid) e_idx = idx;

        if (m_faulted) begin
            m_faulted = 0;
            m_seeded  = 0;
        end else if (m_locked) begin
            if (valid && (step == 1 || step == 0)) begin
                if (step == 1 && idx == 0) begin
                    e_pulse = 1;
                    e_revs  = (e_revs + 1) % (1 << RW);
                end
                m_prev = idx;
            end else begin
                fault     = 1;
                m_locked  = 0;
                m_faulted = 1;
                e_errs    = (e_errs + 1 > (1 << EW) - 1) ? (1 << EW) - 1 : e_errs + 1;
                if (valid) m_prev = idx;
            end
        end else if (m_seeded) begin
            if (!valid) begin
                m_seeded = 0;
            end else if (step == 1) begin
                m_run++;
                m_prev = idx;
                if (m_run == LOCK_LEN) m_locked = 1;
            end else if (step != 0) begin
                m_run  = 0;
                m_prev = idx;
            end
        end else if (valid) begin
            m_seeded = 1;
            m_prev   = idx;
            m_run    = 0;
        end

        if (fault) e_err = 1;
        else if (clr_req) e_err = 0;
    endfunction

    task automatic compare_all(input string where);
        check_value({where, ".phase_idx"},   int'(phase_idx),   e_idx);
        check_value({where, ".phase_valid"}, int'(phase_valid), e_valid);
        check_value({where, ".locked"},      int'(locked),      int'(m_locked));
        check_value({where, ".rev_pulse"},   int'(rev_pulse),   e_pulse);
        check_value({where, ".rev_count"},   int'(rev_count),   e_revs);
        check_value({where, ".err"},         int'(err),         e_err);
        check_value({where, ".err_count"},   int'(err_count),   e_errs);
    endtask

    // Drive one sample at a falling edge; the model follows the coming rising edge
    task automatic drive(input logic [7:0] p, input bit c);
        phase   = p;
        err_clr = c;
        if (clear) model_step(p, c);
    endtask

    function automatic logic [7:0] pick_sample(input int gen_idx, input int fault_pct,
                                               output int next_idx);
        int r, b1, b2;
        logic [7:0] v;
        r = $urandom_range(0, 99);
        next_idx = gen_idx;
        if (r < fault_pct / 3) begin
            v = 8'h00;
        end else if (r < (2 * fault_pct) / 3) begin
            b1 = $urandom_range(0, 7);
            b2 = (b1 + $urandom_range(1, 7)) % 8;
            v  = 8'((1 << b1) | (1 << b2)) | 8'($urandom & $urandom);
        end else if (r < fault_pct) begin
            next_idx = (gen_idx + $urandom_range(2, 7)) % 8;
            v = 8'(1 << next_idx);
        end else if (r < fault_pct + 8) begin
            v = 8'(1 << gen_idx);
        end else begin
            next_idx = (gen_idx + 1) % 8;
            v = 8'(1 << next_idx);
        end
        return v;
    endfunction

    initial begin
        int gen_idx, nxt, rst_hold, fault_pct;
        logic [7:0] p;
        bit c;

        clear   = 1'b0;
        phase   = 8'h01;
        err_clr = 1'b0;
        model_reset();
        gen_idx  = 0;
        rst_hold = 0;

        // Reset held with a valid sample present: nothing may move
        repeat (3) begin
            @(negedge clk);
            compare_all("reset");
        end
        clear = 1'b1;

        // Constant phase 0 after release: seeds and holds, never locks
        for (int i = 0; i < 10; i++) begin
            drive(8'h01, 1'b0);
            @(negedge clk);
            compare_all("hold0");
        end

        for (int cyc = 0; cyc < NCYC; cyc++) begin
            fault_pct = (((cyc / 400) % 2) == 0) ? 2 : 18;
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) clear = 1'b1;
            end else if ($urandom_range(0, 999) < 3) begin
                // Asynchronous reset away from any clock edge
                clear = 1'b0;
                model_reset();
                #1;
                compare_all("async_rst");
                rst_hold = 2;
            end
            p = pick_sample(gen_idx, fault_pct, nxt);
            gen_idx = nxt;
            c = ($urandom_range(0, 99) < 8);
            drive(p, c);
            @(negedge clk);
            compare_all("rand");
            if (e_errs > max_errs_seen) max_errs_seen = e_errs;
            if (e_pulse != 0) revs_seen++;
        end

        // Saturation must have been exercised by the fault-heavy epochs
        check_value("err_count_saturated", max_errs_seen, (1 << EW) - 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
